db_window_avg: RTL and testbench
================================

# db_window_avg

Windowed averager that sits directly downstream of the DDC datapath dB output and upstream of the UART data framer. It turns the 1 MSPS dB stream into one mean value per 2^LOG2_WIN samples, bringing the rate down to something the 115200-baud UART link can carry. A single-entry output register provides valid/ready backpressure and a sticky overrun flag.

## Interface
- DATA_W, 16: width of the dB samples in and out; two's complement.
- LOG2_WIN, 10: log2 of the window length (1024 samples by default); legal range 1..16.
- clk  in  1  system clock (125 MHz)
- rst  in  1  synchronous, active-high reset
- en_i  in  1  enable; low aborts and clears the partial window
- data_i  in  DATA_W  dB sample from the datapath, signed
- valid_i  in  1  data_i qualifier, single-cycle pulses
- data_o  out  DATA_W  window mean, signed
- valid_o  out  1  data_o valid; held until accepted
- ready_i  in  1  downstream accept; transfer occurs when valid_o && ready_i
- peak_o  out  DATA_W  signed maximum of the window; meaningful only when the macro is compiled in
- overrun_o  out  1  sticky flag: a completed window was dropped

## Operation
- Accumulator acc is signed, DATA_W+LOG2_WIN bits. Sample counter cnt is LOG2_WIN bits.
- On valid_i && en_i: acc_next = acc + sext(data_i); cnt increments.
- Window completion: the cnt == 2^LOG2_WIN−1 sample is accepted.
  - Mean = acc_next >>> LOG2_WIN (arithmetic shift; rounds toward −inf).
  - Truncate to DATA_W; this is always in range.
  - acc and cnt clear to 0 in the same edge. There is no dead cycle, so a sample on the next cycle starts the new window.
- Output FSM has two states:
  - EMPTY: valid_o=0. On completion → FULL, loading data_o and peak_o.
  - FULL: valid_o=1; data_o and peak_o are stable.
    - If ready_i and no completion → EMPTY.
    - If ready_i and completion in the same cycle → stay FULL with the new result. No bubble, no overrun.
    - If !ready_i and completion → keep the old result, drop the new one, set overrun_o.
- overrun_o clears only on rst.
- en_i low:
  - acc, cnt and the peak tracker clear at the next edge.
  - valid_i is ignored.
  - The output FSM and a pending result are unaffected; handshaking continues.
- Reset values: data_o=0, peak_o=0, valid_o=0, overrun_o=0, acc=0, cnt=0, FSM=EMPTY.
- Reset mid-window discards the partial window. Reset wins over every simultaneous event.

## Timing
- Latency: the completing sample is accepted at edge t, and valid_o/data_o appear after edge t (visible in cycle t+1). This is one register stage.
- valid_o drops the cycle after a ready_i transfer unless a new completion coincides.
- Throughput: one sample per cycle sustained. valid_i may be continuous.
- ready_i is sampled only while valid_o=1. ready_i while EMPTY has no effect.

## Configuration
- DB_WIN_AVG_PEAK_EN defined:
  - The running max is tracked per window, initialised from the window's first sample.
  - peak_o loads alongside data_o and follows the same hold/drop rules.
- Not defined: no peak logic is built and peak_o is tied to 0.

## Structure
- Shared package ddc_pkg holds:
  - DB_W = 16
  - typedef logic signed [DB_W-1:0] db_t, shared by DataPath, this block and the framer.
- Sub-module db_win_accum holds acc, cnt, peak tracking and en_i clearing. It emits a one-cycle done pulse with mean and peak.
- The top level holds the output FSM and overrun_o.

## Test plan
All scenarios use LOG2_WIN=2 unless stated otherwise.
- Basic mean: samples 10, 20, 30, 40 on consecutive cycles with ready_i=1 → valid_o high for exactly one cycle, the cycle after the 40 sample, with data_o=25; overrun_o=0.
- Negative rounding: samples −3, −3, −3, −2 → data_o=−3 (sum −11, floor of −2.75). Samples −32768 ×4 → data_o=−32768, no wrap.
- Backpressure: ready_i=0, windows {4,4,4,4} then {8,8,8,8} → data_o stays 4 and valid_o stays 1, overrun_o=1 after the 8th sample. Raising ready_i for one cycle then drops valid_o; overrun_o stays 1.
- Same-cycle accept and complete: hold result 4 in FULL and assert ready_i on the cycle the second window completes with mean 8 → next cycle valid_o=1, data_o=8, overrun_o=0.
- en_i and reset abort:
  - Samples 100, 100, then en_i=0 for one cycle, then 0, 0, 0, 0 → data_o=0.
  - Assert rst after 3 samples, then feed 4, 4, 4, 4 → data_o=4.
  - All outputs are 0 during rst.
- Peak (macro on): samples 5, −7, 100, 3 → peak_o=100, data_o=25. With the macro off → peak_o=0.

Source files
------------

// File: rtl/ddc_pkg.sv
// Types shared along the DDC output path: the dB sample type used by the datapath,
// this averager and the UART framer, plus the averager's output-register states.
package ddc_pkg;

  localparam int DB_W = 16;

  typedef logic signed [DB_W-1:0] db_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/db_win_accum.sv
// Window accumulator: sums 2^LOG2_WIN dB samples and pulses done with the floor mean.
// Peak tracking is built only when DB_WIN_AVG_PEAK_EN is defined.
module db_win_accum
  import ddc_pkg::*;
#(
  parameter int DATA_W   = DB_W,
  parameter int LOG2_WIN = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic                     valid_i,
  output logic                     done_o,
  output logic signed [DATA_W-1:0] mean_o,
  output logic signed [DATA_W-1:0] peak_o
);

  localparam int ACC_W = DATA_W + LOG2_WIN;

  // Arithmetic shift floors toward -inf; the quotient of a sum of 2^LOG2_WIN
  // in-range samples always fits back into DATA_W, so truncation is lossless.
  function automatic logic signed [DATA_W-1:0] win_mean(input logic signed [ACC_W-1:0] sum);
    return DATA_W'(sum >>> LOG2_WIN);
  endfunction

  logic signed [ACC_W-1:0]  acc_p0;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [LOG2_WIN-1:0]      cnt_p0;
  logic                     take;
  logic                     last;

  assign take    = valid_i && en_i;
  assign last    = take && (cnt_p0 == {LOG2_WIN{1'b1}});
  assign acc_sum = acc_p0 + $signed({{LOG2_WIN{data_i[DATA_W-1]}}, data_i});

  assign done_o = last;
  assign mean_o = win_mean(acc_sum);

  // p0: running sum and sample count; the completing sample restarts the window
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (take) begin
      if (last) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else begin
        acc_p0 <= acc_sum;
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

`ifdef DB_WIN_AVG_PEAK_EN
  logic signed [DATA_W-1:0] peak_p0;
  logic signed [DATA_W-1:0] peak_nxt;

  // The first sample of a window seeds the max regardless of the stale tracker.
  always_comb begin
    peak_nxt = data_i;
    if ((cnt_p0 != '0) && (peak_p0 > data_i)) peak_nxt = peak_p0;
  end

  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      peak_p0 <= '0;
    end else if (take) begin
      peak_p0 <= last ? '0 : peak_nxt;
    end
  end

  assign peak_o = peak_nxt;
`else
  assign peak_o = '0;
`endif

endmodule

// File: rtl/db_window_avg.sv
// Windowed dB averager with a single-entry valid/ready output register and sticky overrun.
// Optional peak output enabled by defining DB_WIN_AVG_PEAK_EN.
module db_window_avg
  import ddc_pkg::*;
#(
  parameter int DATA_W   = DB_W,
  parameter int LOG2_WIN = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic                     valid_i,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic signed [DATA_W-1:0] peak_o,
  output logic                     overrun_o
);

  logic                     done;
  logic signed [DATA_W-1:0] mean;
  logic signed [DATA_W-1:0] peak;

  db_win_accum #(
    .DATA_W   (DATA_W),
    .LOG2_WIN (LOG2_WIN)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .done_o  (done),
    .mean_o  (mean),
    .peak_o  (peak)
  );

  out_state_t               state_p1;
  out_state_t               state_nxt;
  logic signed [DATA_W-1:0] data_p1;
  logic signed [DATA_W-1:0] peak_p1;
  logic                     ovr_p1;
  logic                     load;
  logic                     ovr_set;

  // A completion coinciding with a transfer refills the register with no bubble.
  always_comb begin
    state_nxt = state_p1;
    load      = 1'b0;
    ovr_set   = 1'b0;
    case (state_p1)
      ST_EMPTY: begin
        if (done) begin
          state_nxt = ST_FULL;
          load      = 1'b1;
        end
      end
      ST_FULL: begin
        if (ready_i) begin
          load      = done;
          state_nxt = done ? ST_FULL : ST_EMPTY;
        end else if (done) begin
          ovr_set = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // p1: output register, one stage after the completing sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_EMPTY;
      data_p1  <= '0;
      peak_p1  <= '0;
      ovr_p1   <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      if (load) begin
        data_p1 <= mean;
        peak_p1 <= peak;
      end
      if (ovr_set) ovr_p1 <= 1'b1;
    end
  end

  assign valid_o   = (state_p1 == ST_FULL);
  assign data_o    = data_p1;
  assign peak_o    = peak_p1;
  assign overrun_o = ovr_p1;

endmodule

// File: tb/tb_db_window_avg.sv
// Directed bench for db_window_avg with a 4-sample window (LOG2_WIN=2).
module tb_db_window_avg;

  localparam int DATA_W   = 16;
  localparam int LOG2_WIN = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en_i;
  logic signed [DATA_W-1:0] data_i;
  logic                     valid_i;
  logic signed [DATA_W-1:0] data_o;
  logic                     valid_o;
  logic                     ready_i;
  logic signed [DATA_W-1:0] peak_o;
  logic                     overrun_o;

  int checks   = 0;
  int failures = 0;

  db_window_avg #(
    .DATA_W   (DATA_W),
    .LOG2_WIN (LOG2_WIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .peak_o    (peak_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    data_i  = DATA_W'(v);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    en_i    = 1'b1;
    data_i  = 16'sd5;
    valid_i = 1'b1;
    ready_i = 1'b1;
    tick();
    tick();
    chk("rst_data", int'(data_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);
    chk("rst_peak", int'(peak_o), 0);
    valid_i = 1'b0;
    rst     = 1'b0;

    // basic mean
    send(10);
    send(20);
    send(30);
    chk("basic_not_early", int'(valid_o), 0);
    send(40);
    chk("basic_valid", int'(valid_o), 1);
    chk("basic_data", int'(data_o), 25);
    chk("basic_overrun", int'(overrun_o), 0);
    tick();
    chk("basic_one_cycle", int'(valid_o), 0);

    // negative rounding toward -inf, and most-negative full scale
    send4(-3, -3, -3, -2);
    chk("neg_floor", int'(data_o), -3);
    tick();
    send4(-32768, -32768, -32768, -32768);
    chk("neg_fullscale", int'(data_o), -32768);
    chk("neg_fullscale_valid", int'(valid_o), 1);
    tick();

    // backpressure and sticky overrun
    ready_i = 1'b0;
    send4(4, 4, 4, 4);
    chk("bp_first_data", int'(data_o), 4);
    chk("bp_first_ovr", int'(overrun_o), 0);
    send4(8, 8, 8, 8);
    chk("bp_hold_data", int'(data_o), 4);
    chk("bp_hold_valid", int'(valid_o), 1);
    chk("bp_overrun", int'(overrun_o), 1);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("bp_drained", int'(valid_o), 0);
    chk("bp_overrun_sticky", int'(overrun_o), 1);
    tick();
    chk("bp_overrun_still", int'(overrun_o), 1);

    // accept and complete in the same cycle
    do_reset();
    chk("ovr_cleared", int'(overrun_o), 0);
    ready_i = 1'b0;
    send4(4, 4, 4, 4);
    send(8);
    send(8);
    send(8);
    chk("same_hold", int'(data_o), 4);
    ready_i = 1'b1;
    send(8);
    chk("same_valid", int'(valid_o), 1);
    chk("same_data", int'(data_o), 8);
    chk("same_overrun", int'(overrun_o), 0);
    tick();
    chk("same_drained", int'(valid_o), 0);

    // en_i abort; the sample offered while disabled must be ignored
    send(100);
    send(100);
    en_i    = 1'b0;
    data_i  = 16'sd100;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    en_i    = 1'b1;
    chk("en_no_result", int'(valid_o), 0);
    send4(0, 0, 0, 0);
    chk("en_valid", int'(valid_o), 1);
    chk("en_data", int'(data_o), 0);
    tick();

    // reset mid-window
    send(8);
    send(8);
    send(8);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", int'(valid_o), 0);
    chk("mid_rst_data", int'(data_o), 0);
    rst = 1'b0;
    send(4);
    chk("mid_rst_no_early", int'(valid_o), 0);
    send(4);
    send(4);
    send(4);
    chk("mid_rst_valid_after", int'(valid_o), 1);
    chk("mid_rst_data_after", int'(data_o), 4);
    tick();

    // peak: sum 101 -> floor 25
    send4(5, -7, 100, 3);
    chk("peak_mean", int'(data_o), 25);
`ifdef DB_WIN_AVG_PEAK_EN
    chk("peak_value", int'(peak_o), 100);
`else
    chk("peak_value", int'(peak_o), 0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
